// File: rtl/ibuf_tech.sv
// Behavioural stand-in for the vendor input buffer cell; swap for the
// technology primitive at implementation time.
module ibuf_tech (
    input  logic i_pad,
    output logic o_data
);

    assign o_data = i_pad;

endmodule

// File: rtl/ibuf_deglitch.sv
// Input pin conditioner: pad buffer, synchroniser, stability filter and
// edge detector for slow external signals such as buttons, straps and IRQs.
module ibuf_deglitch #(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_WIDTH   = 16,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_pad,
    input  logic [CNT_WIDTH-1:0] i_filter_cycles,
    output logic                 o_sync,
    output logic                 o_level,
    output logic                 o_rise,
    output logic                 o_fall,
    output logic                 o_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    logic                   pad_buf;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_in;

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
    logic                   level_reg, level_next;
    logic                   rise_reg, rise_next;
    logic                   fall_reg, fall_next;
    logic                   s;

    ibuf_tech u_ibuf (
        .i_pad  (i_pad),
        .o_data (pad_buf)
    );

    // Stage gi loads from sync_in[gi]: the pad for stage 0, the previous flop otherwise.
    assign sync_in = {sync_reg[SYNC_STAGES-2:0], pad_buf};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge i_clk or negedge i_nrst) begin
                if (!i_nrst) begin
                    sync_reg[gi] <= RESET_LEVEL;
                end else begin
                    sync_reg[gi] <= sync_in[gi];
                end
            end
        end
    endgenerate

    assign s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            level_reg <= RESET_LEVEL;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (s != level_reg) begin
                    if (i_filter_cycles == '0) begin
                        level_next = s;
                        rise_next  = s;
                        fall_next  = ~s;
                    end else begin
                        cnt_next   = CNT_WIDTH'(1);
                        state_next = PEND;
                    end
                end
            end
            PEND: begin
                if (s == level_reg) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt_reg >= i_filter_cycles) begin
                    // >= so a filter value lowered mid-qualification commits at once.
                    level_next = s;
                    rise_next  = s;
                    fall_next  = ~s;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_WIDTH'(1);
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign o_sync  = s;
    assign o_level = level_reg;
    assign o_rise  = rise_reg;
    assign o_fall  = fall_reg;
    assign o_busy  = (state_reg == PEND);

endmodule

// File: tb/tb_ibuf_deglitch.sv
// Directed bench for ibuf_deglitch: one instance with RESET_LEVEL=0 and
// one with RESET_LEVEL=1, expected values worked out by hand per edge.
module tb_ibuf_deglitch;

    logic        clk;
    logic        nrst0, pad0;
    logic [15:0] filt0;
    logic        sync0, level0, rise0, fall0, busy0;
    logic        nrst1, pad1;
    logic [15:0] filt1;
    logic        sync1, level1, rise1, fall1, busy1;

    int n_checks = 0;
    int n_pass   = 0;

    ibuf_deglitch #(.SYNC_STAGES(2), .CNT_WIDTH(16), .RESET_LEVEL(1'b0)) dut0 (
        .i_clk           (clk),
        .i_nrst          (nrst0),
        .i_pad           (pad0),
        .i_filter_cycles (filt0),
        .o_sync          (sync0),
        .o_level         (level0),
        .o_rise          (rise0),
        .o_fall          (fall0),
        .o_busy          (busy0)
    );

    ibuf_deglitch #(.SYNC_STAGES(2), .CNT_WIDTH(16), .RESET_LEVEL(1'b1)) dut1 (
        .i_clk           (clk),
        .i_nrst          (nrst1),
        .i_pad           (pad1),
        .i_filter_cycles (filt1),
        .o_sync          (sync1),
        .o_level         (level1),
        .o_rise          (rise1),
        .o_fall          (fall1),
        .o_busy          (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one rising edge and settle; inputs driven afterwards land before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Toggle-every-2-cycles pad pattern used with N=0; zero outside edges 1..12.
    function automatic logic pat(input int j);
        if (j < 1 || j > 12) return 1'b0;
        return (((j - 1) / 2) % 2) == 0;
    endfunction

    initial begin
        int  rises, falls, busys;
        logic el, elp;

        nrst0 = 1'b0; pad0 = 1'b0; filt0 = 16'd3;
        nrst1 = 1'b0; pad1 = 1'b0; filt1 = 16'd3;

        // Reset state
        tick(); tick();
        check("rst_level", level0, 0);
        check("rst_sync",  sync0,  0);
        check("rst_rise",  rise0,  0);
        check("rst_fall",  fall0,  0);
        check("rst_busy",  busy0,  0);
        nrst0 = 1'b1;
        tick(); tick();
        check("idle_level", level0, 0);

        // 1: N=3, pad 0->1 held: commit 6 edges after the change, busy for 3 cycles before
        pad0 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("t1_level_k%0d", k), level0, (k >= 6));
            check($sformatf("t1_rise_k%0d", k),  rise0,  (k == 6));
            check($sformatf("t1_busy_k%0d", k),  busy0,  (k >= 3 && k <= 5));
            check($sformatf("t1_fall_k%0d", k),  fall0,  0);
        end

        // return low: single fall
        pad0 = 1'b0;
        falls = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (fall0) falls++;
            if (k == 6) check("t1b_fall_k6", fall0, 1);
        end
        check("t1b_falls", falls, 1);
        check("t1b_level", level0, 0);

        // 2a: 1-cycle glitch
        rises = 0; falls = 0; busys = 0;
        for (int k = 1; k <= 10; k++) begin
            pad0 = (k <= 1);
            tick();
            if (rise0) rises++;
            if (fall0) falls++;
            if (busy0) busys++;
            check($sformatf("t2a_level_k%0d", k), level0, 0);
        end
        check("t2a_rises", rises, 0);
        check("t2a_falls", falls, 0);
        check("t2a_busy_cycles", busys, 1);

        // 2b: 3-cycle glitch, still short of N+1=4
        rises = 0; falls = 0; busys = 0;
        for (int k = 1; k <= 10; k++) begin
            pad0 = (k <= 3);
            tick();
            if (rise0) rises++;
            if (fall0) falls++;
            if (busy0) busys++;
            check($sformatf("t2b_level_k%0d", k), level0, 0);
            if (k == 6) check("t2b_busy_drop", busy0, 0);
        end
        check("t2b_rises", rises, 0);
        check("t2b_falls", falls, 0);
        check("t2b_busy_cycles", busys, 3);

        // 3: N=0, pad toggles every 2 cycles; level is the pad pattern 2 edges late
        filt0 = 16'd0;
        for (int j = 1; j <= 12; j++) begin
            pad0 = pat(j);
            tick();
            el  = pat(j - 2);
            elp = pat(j - 3);
            check($sformatf("t3_level_j%0d", j), level0, el);
            check($sformatf("t3_rise_j%0d", j),  rise0,  el & ~elp);
            check($sformatf("t3_fall_j%0d", j),  fall0,  ~el & elp);
            check($sformatf("t3_busy_j%0d", j),  busy0,  0);
        end
        pad0 = 1'b0;
        repeat (4) tick();
        check("t3_end_level", level0, 0);

        // 4: N=10, lowered to 2 once cnt=5 (edge 7): commit on edge 8
        filt0 = 16'd10;
        pad0  = 1'b1;
        rises = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (rise0) rises++;
            if (k == 7) begin
                check("t4_level_k7", level0, 0);
                check("t4_busy_k7",  busy0,  1);
                filt0 = 16'd2;
            end
            if (k == 8) begin
                check("t4_level_k8", level0, 1);
                check("t4_rise_k8",  rise0,  1);
            end
            if (k == 9) check("t4_busy_k9", busy0, 0);
        end
        check("t4_rises", rises, 1);

        // 5: back to low quickly with N=0, then N=8 interrupted by reset at cnt=4
        filt0 = 16'd0;
        pad0  = 1'b0;
        repeat (5) tick();
        check("t5_pre_level", level0, 0);
        filt0 = 16'd8;
        pad0  = 1'b1;
        repeat (6) tick();
        check("t5_busy_cnt4", busy0, 1);
        nrst0 = 1'b0;
        #1;
        check("t5_async_busy",  busy0,  0);
        check("t5_async_sync",  sync0,  0);
        check("t5_async_level", level0, 0);
        tick();
        check("t5_held_sync", sync0, 0);
        nrst0 = 1'b1;
        rises = 0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (rise0) rises++;
            if (k == 10) check("t5_level_k10", level0, 0);
            if (k == 11) check("t5_rise_k11",  rise0,  1);
        end
        check("t5_rises", rises, 1);

        // 6: RESET_LEVEL=1, pad low through release: fall after 2+3+1 edges, never a rise
        check("t6_rst_level", level1, 1);
        check("t6_rst_sync",  sync1,  1);
        nrst1 = 1'b1;
        tick();
        check("t6_rel_level", level1, 1);
        check("t6_rel_fall",  fall1,  0);
        rises = 0; falls = 0;
        for (int k = 2; k <= 9; k++) begin
            tick();
            if (rise1) rises++;
            if (fall1) falls++;
            check($sformatf("t6_level_k%0d", k), level1, (k < 6));
            check($sformatf("t6_fall_k%0d", k),  fall1,  (k == 6));
        end
        check("t6_rises", rises, 0);
        check("t6_falls", falls, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
